// File: rtl/gate_teleport_ctrl_if.sv
// Gate teleport controller bus.
// Frame/collision inputs and mux/strobe outputs.
interface gate_teleport_ctrl_if;
  logic startOfFrame;
  logic enable;
  logic collision_A;
  logic collision_B;
  logic gate_sel;
  logic teleport;
  logic busy;
  logic blink;

  modport master (
    output startOfFrame,
    output enable,
    output collision_A,
    output collision_B,
    input  gate_sel,
    input  teleport,
    input  busy,
    input  blink
  );

  modport slave (
    input  startOfFrame,
    input  enable,
    input  collision_A,
    input  collision_B,
    output gate_sel,
    output teleport,
    output busy,
    output blink
  );
endinterface

// File: rtl/gate_teleport_ctrl.sv
// Gate teleport sequencer for the frog game.
// Picks the destination gate, arms, jumps, cools down.
module gate_teleport_ctrl #(
  parameter int unsigned ARM_FRAMES      = 2,
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input  logic           CLK,
  input  logic           RESETn,
  gate_teleport_ctrl_if.slave bus
);

  localparam int unsigned MAXF =
    (ARM_FRAMES > COOLDOWN_FRAMES) ?
    ARM_FRAMES : COOLDOWN_FRAMES;
  localparam int unsigned CW =
    (MAXF > 0) ? $clog2(MAXF + 1) : 1;

  localparam logic [CW-1:0] ARM_LD  = CW'(ARM_FRAMES);
  localparam logic [CW-1:0] COOL_LD = CW'(COOLDOWN_FRAMES);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] ZERO    = '0;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    JUMP,
    COOLDOWN,
    WAIT_CLEAR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic          tel_q, tel_d;
  logic          busy_q, busy_d;
  logic          blink_q, blink_d;

  logic sof;
  logic any_hit;

  assign sof     = bus.startOfFrame;
  assign any_hit = bus.collision_A | bus.collision_B;

  // state and registered outputs
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      tel_q   <= 1'b0;
      busy_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      tel_q   <= tel_d;
      busy_q  <= busy_d;
      blink_q <= blink_d;
    end
  end

  // next state, frame counting and next outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    tel_d   = 1'b0;
    blink_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable && any_hit) begin
          state_d = ARM;
          sel_d   = bus.collision_A;
          cnt_d   = ARM_LD;
        end
      end
      ARM: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (cnt_q == ZERO) begin
          state_d = JUMP;
          tel_d   = 1'b1;
        end else if (sof) begin
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) begin
            state_d = JUMP;
            tel_d   = 1'b1;
          end else begin
            blink_d = ~blink_q;
          end
        end else begin
          blink_d = blink_q;
        end
      end
      JUMP: begin
        if (COOLDOWN_FRAMES == 0) begin
          state_d = WAIT_CLEAR;
        end else begin
          state_d = COOLDOWN;
          cnt_d   = COOL_LD;
        end
      end
      COOLDOWN: begin
        if (cnt_q == ZERO) begin
          state_d = WAIT_CLEAR;
        end else if (sof) begin
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) begin
            state_d = WAIT_CLEAR;
          end
        end
      end
      WAIT_CLEAR: begin
        if (sof && !any_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.gate_sel = sel_q;
  assign bus.teleport = tel_q;
  assign bus.busy     = busy_q;
  assign bus.blink    = blink_q;

endmodule

// File: tb/tb_gate_teleport_ctrl.sv
// Scoreboard bench for gate_teleport_ctrl.
// Two instances: default timing and zero arm/cooldown.
module tb_gate_teleport_ctrl;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;

  always #5 CLK = ~CLK;

  gate_teleport_ctrl_if if0 ();
  gate_teleport_ctrl_if if1 ();

  gate_teleport_ctrl #(
    .ARM_FRAMES(2),
    .COOLDOWN_FRAMES(30)
  ) u0 (
    .CLK(CLK),
    .RESETn(RESETn),
    .bus(if0.slave)
  );

  gate_teleport_ctrl #(
    .ARM_FRAMES(0),
    .COOLDOWN_FRAMES(0)
  ) u1 (
    .CLK(CLK),
    .RESETn(RESETn),
    .bus(if1.slave)
  );

  typedef enum {M_IDLE, M_ARM, M_JUMP, M_COOL, M_WAIT} ph_t;

  typedef struct {
    ph_t ph;
    int  seen;
    bit  sel;
  } m_t;

  typedef struct packed {
    logic sel;
    logic tel;
    logic busy;
    logic blink;
  } e_t;

  localparam m_t M_RST = '{ph: M_IDLE, seen: 0, sel: 1'b0};

  m_t   m0 = M_RST;
  m_t   m1 = M_RST;
  e_t   q0[$];
  e_t   q1[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;
  event rst_chk;

  // Frame-level behaviour: 'seen' counts frames observed in the phase.
  function automatic m_t mstep(m_t s, int armf, int coolf,
                               bit sof, bit en, bit a, bit b);
    m_t n = s;
    case (s.ph)
      M_IDLE:
        if (en && (a || b)) begin
          n.ph = M_ARM;
          n.sel = a;
          n.seen = 0;
        end
      M_ARM:
        if (!en) n.ph = M_IDLE;
        else if (s.seen == armf) n.ph = M_JUMP;
        else if (sof) begin
          n.seen = s.seen + 1;
          if (n.seen == armf) n.ph = M_JUMP;
        end
      M_JUMP: begin
        n.seen = 0;
        n.ph = (coolf > 0) ? M_COOL : M_WAIT;
      end
      M_COOL:
        if (sof) begin
          n.seen = s.seen + 1;
          if (n.seen >= coolf) n.ph = M_WAIT;
        end
      M_WAIT:
        if (sof && !a && !b) n.ph = M_IDLE;
      default: n = M_RST;
    endcase
    return n;
  endfunction

  function automatic e_t mout(m_t s);
    e_t e;
    e.sel   = s.sel;
    e.tel   = (s.ph == M_JUMP);
    e.busy  = (s.ph != M_IDLE);
    e.blink = (s.ph == M_ARM) && (s.seen % 2 == 1);
    return e;
  endfunction

  task automatic drive(bit s, bit e, bit ca, bit cb);
    if0.startOfFrame = s;
    if0.enable = e;
    if0.collision_A = ca;
    if0.collision_B = cb;
    if1.startOfFrame = s;
    if1.enable = e;
    if1.collision_A = ca;
    if1.collision_B = cb;
  endtask

  task automatic step(bit s, bit e, bit ca, bit cb);
    @(negedge CLK);
    RESETn = 1'b1;
    drive(s, e, ca, cb);
    m0 = mstep(m0, 2, 30, s, e, ca, cb);
    m1 = mstep(m1, 0, 0, s, e, ca, cb);
    q0.push_back(mout(m0));
    q1.push_back(mout(m1));
  endtask

  // Reset mid-cycle: outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge CLK);
    #2;
    RESETn = 1'b0;
    m0 = M_RST;
    m1 = M_RST;
    q0.push_back('0);
    q1.push_back('0);
    -> rst_chk;
    q0.push_back('0);
    q1.push_back('0);
    @(negedge CLK);
    q0.push_back('0);
    q1.push_back('0);
  endtask

  task automatic frames(int n, bit e, bit ca, bit cb);
    for (int f = 0; f < n; f++) begin
      step(1'b1, e, ca, cb);
      for (int c = 0; c < 4; c++) step(1'b0, e, ca, cb);
    end
  endtask

  function automatic void cmp(e_t exp, e_t act, string nm);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t sel/tel/busy/blink got %b want %b",
               nm, $time, act, exp);
    end
  endfunction

  // Monitor: one expected entry per clock edge or reset probe.
  initial begin
    @(negedge CLK);
    forever begin
      @(posedge CLK or rst_chk);
      #1;
      if (done) break;
      if (q0.size() == 0 || q1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL underrun t=%0t got empty want entry", $time);
      end else begin
        cmp(q0.pop_front(),
            e_t'({if0.gate_sel, if0.teleport, if0.busy, if0.blink}),
            "dut_arm2_cool30");
        cmp(q1.pop_front(),
            e_t'({if1.gate_sel, if1.teleport, if1.busy, if1.blink}),
            "dut_arm0_cool0");
      end
    end
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL leftover got %0d/%0d want 0/0",
               q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  // Stimulus: directed scenarios, then random traffic.
  initial begin
    int fc;
    bit ra, rb, ren, rs;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    frames(3, 1'b1, 1'b0, 1'b0);
    frames(40, 1'b1, 1'b0, 1'b1);
    frames(2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    frames(3, 1'b1, 1'b0, 1'b0);
    frames(33, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    frames(1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    frames(2, 1'b0, 1'b0, 1'b0);
    frames(1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    frames(4, 1'b1, 1'b0, 1'b0);
    do_reset();
    frames(2, 1'b1, 1'b0, 1'b0);
    fc = 0;
    ra = 1'b0;
    rb = 1'b0;
    ren = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) ra = ~ra;
      if ($urandom_range(0, 9) == 0) rb = ~rb;
      if ($urandom_range(0, 24) == 0) ren = ~ren;
      rs = (fc == 0);
      fc = (fc == 0) ? int'($urandom_range(2, 7)) : fc - 1;
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(rs, ren, ra, rb);
    end
    @(negedge CLK);
    done = 1'b1;
  end

endmodule
